// File: rtl/umi_addr_remap_pkg.sv
// umi_addr_remap_pkg
//   Shared UMI width constants for the address remapper. The values below are
//   the default parameter values of umi_addr_remap and umi_addr_remap_xlate.
//   No ports (package only).
package umi_addr_remap_pkg;

  localparam int UMI_CW    = 32;   // command width
  localparam int UMI_AW    = 64;   // address width
  localparam int UMI_DW    = 256;  // data width
  localparam int UMI_IDW   = 16;   // row/column ID field width
  localparam int UMI_IDSB  = 40;   // LSB of the ID field inside dstaddr
  localparam int UMI_NMAPS = 8;    // number of map table entries

endpackage

// File: rtl/umi_addr_remap_xlate.sv
// umi_addr_remap_xlate
//   Purely combinational destination-address translator.
//   Priority: offset window, then local chip ID (pass-through),
//   then map table (lowest matching index wins), then pass-through.
// Ports:
//   chipid                 local chip ID
//   old_row_col_address    packed match values, entry i at [IDW*i +: IDW]
//   new_row_col_address    packed replacement values, same packing
//   set_dstaddress_low     window low bound, inclusive
//   set_dstaddress_high    window high bound, inclusive
//   set_dstaddress_offset  value added to addresses inside the window
//   dstaddr_in             incoming destination address
//   dstaddr_out            translated destination address
module umi_addr_remap_xlate
  import umi_addr_remap_pkg::*;
#(
  parameter int AW    = UMI_AW,
  parameter int IDW   = UMI_IDW,
  parameter int IDSB  = UMI_IDSB,
  parameter int NMAPS = UMI_NMAPS
) (
  input  logic [IDW-1:0]       chipid,
  input  logic [IDW*NMAPS-1:0] old_row_col_address,
  input  logic [IDW*NMAPS-1:0] new_row_col_address,
  input  logic [AW-1:0]        set_dstaddress_low,
  input  logic [AW-1:0]        set_dstaddress_high,
  input  logic [AW-1:0]        set_dstaddress_offset,
  input  logic [AW-1:0]        dstaddr_in,
  output logic [AW-1:0]        dstaddr_out
);

  logic [IDW-1:0] w_field;
  logic [IDW-1:0] w_new_field;
  logic           w_map_hit;
  logic           w_in_window;
  logic [AW-1:0]  w_mapped;
  logic [AW-1:0]  w_offset_addr;

  assign w_field = dstaddr_in[IDSB +: IDW];

  // Walk the table from the top down so the lowest matching index is the
  // last assignment and therefore wins on duplicate entries.
  always_comb begin
    w_map_hit   = 1'b0;
    w_new_field = w_field;
    for (int i = NMAPS - 1; i >= 0; i--) begin
      if (old_row_col_address[IDW*i +: IDW] == w_field) begin
        w_map_hit   = 1'b1;
        w_new_field = new_row_col_address[IDW*i +: IDW];
      end
    end
  end

  assign w_in_window = (dstaddr_in >= set_dstaddress_low) &&
                       (dstaddr_in <= set_dstaddress_high);

  // Same-width add: the carry out of the MSB is dropped (modulo 2^AW).
  assign w_offset_addr = dstaddr_in + set_dstaddress_offset;

  always_comb begin
    w_mapped                = dstaddr_in;
    w_mapped[IDSB +: IDW]   = w_new_field;
  end

  always_comb begin
    dstaddr_out = dstaddr_in;
    if (w_in_window) begin
      dstaddr_out = w_offset_addr;
    end else if (w_field == chipid) begin
      dstaddr_out = dstaddr_in;
    end else if (w_map_hit) begin
      dstaddr_out = w_mapped;
    end
  end

endmodule

// File: rtl/umi_addr_remap.sv
// umi_addr_remap
//   UMI request-path address translator with one registered output stage.
//   dstaddr is rewritten by umi_addr_remap_xlate; cmd, srcaddr and data pass
//   through unchanged. Full throughput: the register reloads on the same edge
//   it is drained.
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   chipid, old/new_row_col_address, set_dstaddress_*   quasi-static config
//   umi_in_*                    input packet and valid/ready handshake
//   umi_out_*                   registered output packet and handshake
module umi_addr_remap
  import umi_addr_remap_pkg::*;
#(
  parameter int CW    = UMI_CW,
  parameter int AW    = UMI_AW,
  parameter int DW    = UMI_DW,
  parameter int IDW   = UMI_IDW,
  parameter int IDSB  = UMI_IDSB,
  parameter int NMAPS = UMI_NMAPS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDW-1:0]       chipid,
  input  logic [IDW*NMAPS-1:0] old_row_col_address,
  input  logic [IDW*NMAPS-1:0] new_row_col_address,
  input  logic [AW-1:0]        set_dstaddress_low,
  input  logic [AW-1:0]        set_dstaddress_high,
  input  logic [AW-1:0]        set_dstaddress_offset,
  input  logic                 umi_in_valid,
  output logic                 umi_in_ready,
  input  logic [CW-1:0]        umi_in_cmd,
  input  logic [AW-1:0]        umi_in_dstaddr,
  input  logic [AW-1:0]        umi_in_srcaddr,
  input  logic [DW-1:0]        umi_in_data,
  output logic                 umi_out_valid,
  input  logic                 umi_out_ready,
  output logic [CW-1:0]        umi_out_cmd,
  output logic [AW-1:0]        umi_out_dstaddr,
  output logic [AW-1:0]        umi_out_srcaddr,
  output logic [DW-1:0]        umi_out_data
);

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic [AW-1:0] w_dstaddr_new;

  logic          r_valid;
  logic [CW-1:0] r_cmd;
  logic [AW-1:0] r_dstaddr;
  logic [AW-1:0] r_srcaddr;
  logic [DW-1:0] r_data;

  umi_addr_remap_xlate #(
    .AW    (AW),
    .IDW   (IDW),
    .IDSB  (IDSB),
    .NMAPS (NMAPS)
  ) u_xlate (
    .chipid                (chipid),
    .old_row_col_address   (old_row_col_address),
    .new_row_col_address   (new_row_col_address),
    .set_dstaddress_low    (set_dstaddress_low),
    .set_dstaddress_high   (set_dstaddress_high),
    .set_dstaddress_offset (set_dstaddress_offset),
    .dstaddr_in            (umi_in_dstaddr),
    .dstaddr_out           (w_dstaddr_new)
  );

  // Ready only looks at the register and the downstream ready, never at
  // umi_in_valid, so there is no valid->valid combinational path.
  assign umi_in_ready = !r_valid || umi_out_ready;
  assign w_in_xfer    = umi_in_valid && umi_in_ready;
  assign w_out_xfer   = r_valid && umi_out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_cmd     <= '0;
      r_dstaddr <= '0;
      r_srcaddr <= '0;
      r_data    <= '0;
    end else if (w_in_xfer) begin
      r_valid   <= 1'b1;
      r_cmd     <= umi_in_cmd;
      r_dstaddr <= w_dstaddr_new;
      r_srcaddr <= umi_in_srcaddr;
      r_data    <= umi_in_data;
    end else if (w_out_xfer) begin
      r_valid   <= 1'b0;
    end
  end

  assign umi_out_valid   = r_valid;
  assign umi_out_cmd     = r_cmd;
  assign umi_out_dstaddr = r_dstaddr;
  assign umi_out_srcaddr = r_srcaddr;
  assign umi_out_data    = r_data;

endmodule

// File: tb/tb_umi_addr_remap.sv
module tb_umi_addr_remap;

  localparam int CW = 32, AW = 64, DW = 256, IDW = 16, IDSB = 40, NMAPS = 8;

  typedef struct {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } pkt_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [IDW-1:0]       chipid;
  logic [IDW*NMAPS-1:0] old_flat, new_flat;
  logic [AW-1:0]        cfg_low, cfg_high, cfg_offset;
  logic                 umi_in_valid, umi_in_ready;
  logic [CW-1:0]        umi_in_cmd;
  logic [AW-1:0]        umi_in_dstaddr, umi_in_srcaddr;
  logic [DW-1:0]        umi_in_data;
  logic                 umi_out_valid, umi_out_ready;
  logic [CW-1:0]        umi_out_cmd;
  logic [AW-1:0]        umi_out_dstaddr, umi_out_srcaddr;
  logic [DW-1:0]        umi_out_data;

  logic [IDW-1:0] cfg_old [NMAPS];
  logic [IDW-1:0] cfg_new [NMAPS];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  always_comb begin
    old_flat = '0;
    new_flat = '0;
    for (int i = 0; i < NMAPS; i++) begin
      old_flat[IDW*i +: IDW] = cfg_old[i];
      new_flat[IDW*i +: IDW] = cfg_new[i];
    end
  end

  umi_addr_remap dut (
    .clk                   (clk),
    .reset                 (reset),
    .chipid                (chipid),
    .old_row_col_address   (old_flat),
    .new_row_col_address   (new_flat),
    .set_dstaddress_low    (cfg_low),
    .set_dstaddress_high   (cfg_high),
    .set_dstaddress_offset (cfg_offset),
    .umi_in_valid          (umi_in_valid),
    .umi_in_ready          (umi_in_ready),
    .umi_in_cmd            (umi_in_cmd),
    .umi_in_dstaddr        (umi_in_dstaddr),
    .umi_in_srcaddr        (umi_in_srcaddr),
    .umi_in_data           (umi_in_data),
    .umi_out_valid         (umi_out_valid),
    .umi_out_ready         (umi_out_ready),
    .umi_out_cmd           (umi_out_cmd),
    .umi_out_dstaddr       (umi_out_dstaddr),
    .umi_out_srcaddr       (umi_out_srcaddr),
    .umi_out_data          (umi_out_data)
  );

  // Reference: the address rules evaluated directly in priority order.
  function automatic logic [AW-1:0] model_remap(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    logic [IDW-1:0] f;
    r = a;
    f = a[IDSB +: IDW];
    if (a >= cfg_low && a <= cfg_high) return a + cfg_offset;
    if (f == chipid) return a;
    for (int i = 0; i < NMAPS; i++) begin
      if (cfg_old[i] == f) begin
        r[IDSB +: IDW] = cfg_new[i];
        return r;
      end
    end
    return a;
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    int sel;
    p.cmd = $urandom;
    p.src = {$urandom, $urandom};
    for (int k = 0; k < DW / 32; k++) p.data[32*k +: 32] = $urandom;
    sel = $urandom_range(0, 3);
    if (sel == 0) begin
      p.dst = cfg_low + 64'($urandom_range(0, 1000));
    end else begin
      p.dst = {$urandom, $urandom};
      p.dst[63:56] = 8'h00;
      p.dst[IDSB +: IDW] = 16'($urandom_range(0, 12));
    end
    return p;
  endfunction

  task automatic drive_pkt(input pkt_t p);
    umi_in_cmd     = p.cmd;
    umi_in_dstaddr = p.dst;
    umi_in_srcaddr = p.src;
    umi_in_data    = p.data;
  endtask

  task automatic set_default_cfg();
    chipid     = 16'h0004;
    for (int i = 0; i < NMAPS; i++) begin
      cfg_old[i] = 16'(i);
      cfg_new[i] = ~16'(i);
    end
    cfg_low    = 64'h0000_0600_0000_0080;
    cfg_high   = 64'h0000_06FF_FFFF_FFFF;
    cfg_offset = 64'hFFFF_FFFF_FFFF_FF80;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    umi_in_valid = 1'b0;
    umi_out_ready = 1'b0;
    drive_pkt('{cmd: '0, dst: '0, src: '0, data: '0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (umi_out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", umi_out_valid);
    else n_pass++;
    n_checks++;
    if (umi_in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", umi_in_ready);
    else n_pass++;
    n_checks++;
    if ({umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr} !== '0 || umi_out_data !== '0)
      $display("FAIL reset_fields got dst=%h cmd=%h want 0", umi_out_dstaddr, umi_out_cmd);
    else n_pass++;
  endtask

  // Send one packet with out_ready=1 and check it one edge later.
  task automatic run_one(input string name, input logic [AW-1:0] dst,
                         input logic [AW-1:0] exp_dst);
    pkt_t p;
    p = rand_pkt();
    p.dst = dst;
    @(negedge clk);
    drive_pkt(p);
    umi_in_valid = 1'b1;
    umi_out_ready = 1'b1;
    #1;
    n_checks++;
    if (umi_in_ready !== 1'b1) $display("FAIL %s_in_ready got %b want 1", name, umi_in_ready);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    umi_in_valid = 1'b0;
    n_checks++;
    if (umi_out_valid !== 1'b1) $display("FAIL %s_valid got %b want 1", name, umi_out_valid);
    else n_pass++;
    n_checks++;
    if (umi_out_dstaddr !== exp_dst)
      $display("FAIL %s_dst got %h want %h", name, umi_out_dstaddr, exp_dst);
    else n_pass++;
    n_checks++;
    if (umi_out_cmd !== p.cmd || umi_out_srcaddr !== p.src || umi_out_data !== p.data)
      $display("FAIL %s_passthru got cmd=%h src=%h want cmd=%h src=%h", name,
               umi_out_cmd, umi_out_srcaddr, p.cmd, p.src);
    else n_pass++;
    @(posedge clk);
  endtask

  task automatic test_map_hit();
    run_one("map_hit", 64'h0000_0100_0000_1234, 64'h00FF_FE00_0000_1234);
  endtask

  task automatic test_local_miss();
    run_one("local", 64'h0000_0400_0000_0010, 64'h0000_0400_0000_0010);
    run_one("miss",  64'h0000_0900_0000_0010, 64'h0000_0900_0000_0010);
  endtask

  task automatic test_window();
    run_one("win_mid",   64'h0000_0600_0000_0100, 64'h0000_0600_0000_0080);
    run_one("win_low",   64'h0000_0600_0000_0080, 64'h0000_0600_0000_0000);
    run_one("win_below", 64'h0000_0600_0000_007F, 64'h00FF_F900_0000_007F);
    run_one("win_high",  64'h0000_06FF_FFFF_FFFF, 64'h0000_06FF_FFFF_FF7F);
  endtask

  task automatic test_dup_map();
    cfg_old[2] = 16'h0033;
    cfg_old[5] = 16'h0033;
    run_one("dup_map", 64'h0000_3300_0000_0042, 64'h00FF_FD00_0000_0042);
    set_default_cfg();
  endtask

  task automatic test_backpressure();
    pkt_t exp_q[$];
    pkt_t p, e, held;
    int sent = 0, recv = 0, cycles = 0;
    bit acc_last = 0, stalled = 0, in_x, out_x;
    umi_in_valid = 1'b0;
    while (recv < 100 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (stalled) begin
        n_checks++;
        if (umi_out_valid !== 1'b1 || umi_out_dstaddr !== held.dst || umi_out_cmd !== held.cmd ||
            umi_out_srcaddr !== held.src || umi_out_data !== held.data)
          $display("FAIL bp_stable got v=%b dst=%h want v=1 dst=%h", umi_out_valid,
                   umi_out_dstaddr, held.dst);
        else n_pass++;
      end
      if (acc_last) umi_in_valid = 1'b0;
      if (!umi_in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        p = rand_pkt();
        drive_pkt(p);
        umi_in_valid = 1'b1;
      end
      umi_out_ready = ($urandom_range(0, 2) != 0);
      #1;
      in_x  = umi_in_valid && umi_in_ready;
      out_x = umi_out_valid && umi_out_ready;
      if (out_x) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL bp_extra got dst=%h want no packet", umi_out_dstaddr);
        end else begin
          e = exp_q.pop_front();
          if (umi_out_dstaddr !== e.dst || umi_out_cmd !== e.cmd ||
              umi_out_srcaddr !== e.src || umi_out_data !== e.data)
            $display("FAIL bp_pkt%0d got dst=%h cmd=%h want dst=%h cmd=%h", recv,
                     umi_out_dstaddr, umi_out_cmd, e.dst, e.cmd);
          else n_pass++;
        end
        recv++;
      end
      stalled = umi_out_valid && !umi_out_ready;
      held.cmd  = umi_out_cmd;
      held.dst  = umi_out_dstaddr;
      held.src  = umi_out_srcaddr;
      held.data = umi_out_data;
      if (in_x) begin
        e.cmd  = umi_in_cmd;
        e.dst  = model_remap(umi_in_dstaddr);
        e.src  = umi_in_srcaddr;
        e.data = umi_in_data;
        exp_q.push_back(e);
        sent++;
      end
      acc_last = in_x;
    end
    n_checks++;
    if (recv != 100) $display("FAIL bp_count got %0d want 100 (cycle budget)", recv);
    else n_pass++;
    @(negedge clk);
    umi_in_valid = 1'b0;
    umi_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (umi_out_valid !== 1'b0 || exp_q.size() != 0)
      $display("FAIL bp_drain got v=%b left=%0d want v=0 left=0", umi_out_valid, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    pkt_t p;
    logic [AW-1:0] exp_dst [$];
    umi_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (umi_out_valid !== 1'b1 || umi_out_dstaddr !== exp_dst[i-1])
          $display("FAIL b2b_pkt%0d got v=%b dst=%h want v=1 dst=%h", i - 1, umi_out_valid,
                   umi_out_dstaddr, exp_dst[i-1]);
        else n_pass++;
      end
      p = rand_pkt();
      drive_pkt(p);
      exp_dst.push_back(model_remap(p.dst));
      umi_in_valid = 1'b1;
      #1;
      n_checks++;
      if (umi_in_ready !== 1'b1) $display("FAIL b2b_ready%0d got %b want 1", i, umi_in_ready);
      else n_pass++;
    end
    @(negedge clk);
    umi_in_valid = 1'b0;
    n_checks++;
    if (umi_out_valid !== 1'b1 || umi_out_dstaddr !== exp_dst[19])
      $display("FAIL b2b_last got v=%b dst=%h want v=1 dst=%h", umi_out_valid,
               umi_out_dstaddr, exp_dst[19]);
    else n_pass++;
    @(posedge clk);
  endtask

  task automatic test_reset_midstream();
    pkt_t p;
    @(negedge clk);
    p = rand_pkt();
    drive_pkt(p);
    umi_in_valid = 1'b1;
    umi_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    umi_in_valid = 1'b0;
    n_checks++;
    if (umi_out_valid !== 1'b1) $display("FAIL rst_mid_loaded got %b want 1", umi_out_valid);
    else n_pass++;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (umi_out_valid !== 1'b0 || umi_in_ready !== 1'b1)
      $display("FAIL rst_mid_valid got v=%b rdy=%b want v=0 rdy=1", umi_out_valid, umi_in_ready);
    else n_pass++;
    n_checks++;
    if ({umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr} !== '0 || umi_out_data !== '0)
      $display("FAIL rst_mid_fields got dst=%h cmd=%h want 0", umi_out_dstaddr, umi_out_cmd);
    else n_pass++;
    reset = 1'b0;
    run_one("after_rst", 64'h0000_0300_0000_5555, 64'h00FF_FC00_0000_5555);
  endtask

  initial begin
    set_default_cfg();
    test_reset();
    test_map_hit();
    test_local_miss();
    test_window();
    test_dup_map();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
